// File: rtl/mips32_multicycle_core.sv
// Multi-cycle MIPS32 subset core: FSM-sequenced datapath, one shared
// req/ready memory port, precise halt-on-fault and a retire pulse.
module mips32_multicycle_core #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [31:0]       pc_out
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } aluOp_e;

    localparam logic [32:0] ADDR_LIMIT = 33'd1 << ADDR_W;

    state_e      state;
    state_e      nextState;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [31:0] aluOut;
    logic [31:0] mdr;
    logic [1:0]  cause;
    logic [31:0] regFile [32];

    logic [5:0]  opc;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [4:0]  unusedShamt;

    assign opc         = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign unusedShamt = ir[10:6];
    assign func        = ir[5:0];
    assign imm16       = ir[15:0];

    logic   instValid;
    logic   isRType;
    logic   isLw;
    logic   isSw;
    logic   isBeq;
    logic   isBne;
    logic   isJ;
    logic   zeroExt;
    aluOp_e aluOp;

    always_comb begin
        instValid = 1'b1;
        isRType   = 1'b0;
        isLw      = 1'b0;
        isSw      = 1'b0;
        isBeq     = 1'b0;
        isBne     = 1'b0;
        isJ       = 1'b0;
        zeroExt   = 1'b0;
        aluOp     = ALU_ADD;
        case (opc)
            6'h00: begin
                isRType = 1'b1;
                case (func)
                    6'h20:   aluOp = ALU_ADD;
                    6'h22:   aluOp = ALU_SUB;
                    6'h24:   aluOp = ALU_AND;
                    6'h25:   aluOp = ALU_OR;
                    6'h2A:   aluOp = ALU_SLT;
                    default: instValid = 1'b0;
                endcase
            end
            6'h08: aluOp = ALU_ADD;
            6'h0A: aluOp = ALU_SLT;
            6'h0C: begin
                aluOp   = ALU_AND;
                zeroExt = 1'b1;
            end
            6'h0D: begin
                aluOp   = ALU_OR;
                zeroExt = 1'b1;
            end
            6'h23:   isLw  = 1'b1;
            6'h2B:   isSw  = 1'b1;
            6'h04:   isBeq = 1'b1;
            6'h05:   isBne = 1'b1;
            6'h02:   isJ   = 1'b1;
            default: instValid = 1'b0;
        endcase
    end

    logic        isCtrl;
    logic        isMem;
    logic [31:0] imm32;
    logic [31:0] aluB;
    logic [31:0] aluResult;
    logic        branchTaken;
    logic [31:0] ctrlTarget;
    logic        pcInRange;
    logic        addrOk;
    logic [4:0]  destReg;
    logic [31:0] rdA;
    logic [31:0] rdB;

    assign isCtrl = isBeq | isBne | isJ;
    assign isMem  = isLw | isSw;
    assign imm32  = zeroExt ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    assign aluB   = isRType ? regB : imm32;

    always_comb begin
        aluResult = regA + aluB;
        case (aluOp)
            ALU_SUB: aluResult = regA - aluB;
            ALU_AND: aluResult = regA & aluB;
            ALU_OR:  aluResult = regA | aluB;
            ALU_SLT: aluResult = {31'd0, $signed(regA) < $signed(aluB)};
            default: aluResult = regA + aluB;
        endcase
    end

    assign branchTaken = isJ | (isBeq & (regA == regB)) | (isBne & (regA != regB));
    assign ctrlTarget  = isJ ? {npc[31:28], ir[25:0], 2'b00}
                             : npc + {imm32[29:0], 2'b00};

    // Range checks are done on 33 bits so ADDR_W may approach 32.
    assign pcInRange = {1'b0, pc} < ADDR_LIMIT;
    assign addrOk    = (aluResult[1:0] == 2'b00) && ({1'b0, aluResult} < ADDR_LIMIT);
    assign destReg   = isRType ? rd : rt;
    assign rdA       = (rs == 5'd0) ? 32'd0 : regFile[rs];
    assign rdB       = (rt == 5'd0) ? 32'd0 : regFile[rt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH: begin
                if (!pcInRange) begin
                    nextState = HALT;
                end else if (mem_ready) begin
                    nextState = DECODE;
                end
            end
            DECODE: nextState = instValid ? EXEC : HALT;
            EXEC: begin
                if (isCtrl) begin
                    nextState = FETCH;
                end else if (isMem) begin
                    nextState = addrOk ? MEM : HALT;
                end else begin
                    nextState = WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    nextState = isSw ? FETCH : WB;
                end
            end
            WB:      nextState = FETCH;
            default: nextState = HALT;
        endcase
    end

    // Gated by rst so an async reset drops the request in the same cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        if (rst) begin
            case (state)
                FETCH: begin
                    if (pcInRange) begin
                        mem_req  = 1'b1;
                        mem_addr = pc[ADDR_W-1:0];
                    end
                end
                EXEC: retire = isCtrl;
                MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = isSw;
                    mem_addr  = aluOut[ADDR_W-1:0];
                    mem_wdata = isSw ? regB : 32'd0;
                    retire    = isSw & mem_ready;
                end
                WB:      retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            npc    <= '0;
            ir     <= '0;
            regA   <= '0;
            regB   <= '0;
            aluOut <= '0;
            mdr    <= '0;
            cause  <= 2'd0;
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!pcInRange) begin
                        cause <= 2'd3;
                    end else if (mem_ready) begin
                        ir  <= mem_rdata;
                        npc <= pc + 32'd4;
                    end
                end
                DECODE: begin
                    regA <= rdA;
                    regB <= rdB;
                    if (!instValid) begin
                        cause <= 2'd1;
                    end
                end
                EXEC: begin
                    aluOut <= aluResult;
                    if (isCtrl) begin
                        pc <= branchTaken ? ctrlTarget : npc;
                    end else if (isMem && !addrOk) begin
                        cause <= 2'd2;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (isSw) begin
                            pc <= npc;
                        end else begin
                            mdr <= mem_rdata;
                        end
                    end
                end
                WB: begin
                    if (destReg != 5'd0) begin
                        regFile[destReg] <= isLw ? mdr : aluOut;
                    end
                    pc <= npc;
                end
                default: ;
            endcase
        end
    end

    assign halted     = (state == HALT);
    assign halt_cause = cause;
    assign pc_out     = pc;

endmodule

// File: tb/tb_mips32_multicycle_core.sv
// Directed bench for mips32_multicycle_core: small programs in a
// behavioural memory with configurable wait states.
module tb_mips32_multicycle_core;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        retire;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] pc_out;

    mips32_multicycle_core #(
        .ADDR_W  (10),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .halted    (halted),
        .halt_cause(halt_cause),
        .pc_out    (pc_out)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];
    int          waits = 0;
    logic        readyHold = 1'b0;
    int          waitCnt = 0;
    int          posCount = 0;
    int          relPos = 0;
    int          reqCnt = 0;
    int          retCyc [$];
    logic [31:0] retPc [$];
    logic [9:0]  wrAddr [$];
    logic [31:0] wrData [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = !readyHold && (waitCnt >= waits);

    always @(posedge clk) begin
        posCount <= posCount + 1;
        if (!mem_req || mem_ready) begin
            waitCnt <= 0;
        end else begin
            waitCnt <= waitCnt + 1;
        end
        if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (retire) begin
                retCyc.push_back(posCount - relPos + 1);
                retPc.push_back(pc_out);
            end
            if (mem_req) begin
                reqCnt = reqCnt + 1;
            end
            if (mem_req && mem_we && mem_ready) begin
                wrAddr.push_back(mem_addr);
                wrData.push_back(mem_wdata);
            end
        end
    end

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic startRun();
        rst = 1'b0;
        retCyc.delete();
        retPc.delete();
        wrAddr.delete();
        wrData.delete();
        reqCnt = 0;
        repeat (2) @(posedge clk);
        #1;
        relPos = posCount;
        rst    = 1'b1;
    endtask

    task automatic waitHalt(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout halted=%b want 1", name, halted);
        end
    endtask

    task automatic test_reset();
        clearMem();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, retire, halted, halt_cause} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {mem_req, mem_we, retire, halted, halt_cause});
        end
        checks++;
        if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h want 0", pc_out);
        end
    endtask

    task automatic test_alu();
        int          expCyc [6] = '{4, 8, 12, 16, 20, 24};
        logic [31:0] expPc  [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        clearMem();
        waits     = 0;
        readyHold = 1'b0;
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_FFFD;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'h0041_202A;
        mem[4] = 32'hAC03_0080;
        mem[5] = 32'hAC04_0084;
        startRun();
        waitHalt(200, "alu");
        checks++;
        if (retCyc.size() != 6) begin
            errors++;
            $display("FAIL alu_retire_count got %0d want 6", retCyc.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (retCyc[i] != expCyc[i] || retPc[i] !== expPc[i]) begin
                errors++;
                $display("FAIL alu_retire%0d got cyc=%0d pc=%h want cyc=%0d pc=%h",
                         i, retCyc[i], retPc[i], expCyc[i], expPc[i]);
            end
        end
        checks++;
        if (wrData.size() != 2 || wrAddr[0] !== 10'h80 || wrData[0] !== 32'd2) begin
            errors++;
            $display("FAIL alu_r3 got addr=%h data=%h want 080 2", wrAddr[0], wrData[0]);
        end
        checks++;
        if (wrAddr[1] !== 10'h84 || wrData[1] !== 32'd1) begin
            errors++;
            $display("FAIL alu_r4 got addr=%h data=%h want 084 1", wrAddr[1], wrData[1]);
        end
        checks++;
        if (halt_cause !== 2'd1 || pc_out !== 32'h18) begin
            errors++;
            $display("FAIL alu_halt got cause=%0d pc=%h want 1 18", halt_cause, pc_out);
        end
    endtask

    task automatic test_wait_states();
        clearMem();
        waits  = 3;
        mem[0] = 32'h2001_0007;
        mem[1] = 32'hAC01_0080;
        startRun();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h0}) begin
                errors++;
                $display("FAIL wait_hold%0d got req=%b we=%b addr=%h want 1 0 000",
                         c, mem_req, mem_we, mem_addr);
            end
            checks++;
            if (mem_ready !== (c == 4)) begin
                errors++;
                $display("FAIL wait_ready%0d got %b want %b", c, mem_ready, c == 4);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_req_drop got %b want 0", mem_req);
        end
        waitHalt(200, "wait");
        checks++;
        if (retCyc.size() != 2 || retCyc[0] != 7 || retCyc[1] != 17) begin
            errors++;
            $display("FAIL wait_retire got n=%0d c0=%0d c1=%0d want 2 7 17",
                     retCyc.size(), retCyc[0], retCyc[1]);
        end
        checks++;
        if (wrData.size() != 1 || wrData[0] !== 32'd7) begin
            errors++;
            $display("FAIL wait_store got %h want 7", wrData[0]);
        end
        checks++;
        if (pc_out !== 32'h8 || halt_cause !== 2'd1) begin
            errors++;
            $display("FAIL wait_halt got pc=%h cause=%0d want 8 1", pc_out, halt_cause);
        end
        waits = 0;
    endtask

    task automatic test_load_store();
        int          expCyc  [6] = '{4, 8, 13, 17, 21, 25};
        logic [9:0]  expAddr [3] = '{10'h40, 10'h44, 10'h48};
        logic [31:0] expData [3] = '{32'h55, 32'h55, 32'h0};
        clearMem();
        mem[0] = 32'h2001_0055;
        mem[1] = 32'hAC01_0040;
        mem[2] = 32'h8C02_0040;
        mem[3] = 32'hAC02_0044;
        mem[4] = 32'h2000_0009;
        mem[5] = 32'hAC00_0048;
        startRun();
        waitHalt(200, "ldst");
        checks++;
        if (retCyc.size() != 6) begin
            errors++;
            $display("FAIL ldst_retire_count got %0d want 6", retCyc.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (retCyc[i] != expCyc[i]) begin
                errors++;
                $display("FAIL ldst_cyc%0d got %0d want %0d", i, retCyc[i], expCyc[i]);
            end
        end
        checks++;
        if (wrAddr.size() != 3) begin
            errors++;
            $display("FAIL ldst_write_count got %0d want 3", wrAddr.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wrAddr[i] !== expAddr[i] || wrData[i] !== expData[i]) begin
                errors++;
                $display("FAIL ldst_write%0d got %h/%h want %h/%h",
                         i, wrAddr[i], wrData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_control_flow();
        int          expCyc [6] = '{4, 8, 11, 14, 17, 21};
        logic [31:0] expPc  [6] = '{32'h0, 32'h4, 32'h8, 32'h14, 32'h18, 32'h40};
        clearMem();
        mem[0]  = 32'h2001_0001;
        mem[1]  = 32'h2002_0001;
        mem[2]  = 32'h1022_0002;
        mem[5]  = 32'h1422_0005;
        mem[6]  = 32'h0800_0010;
        mem[16] = 32'hAC01_0080;
        startRun();
        waitHalt(200, "ctrl");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (retCyc[i] != expCyc[i] || retPc[i] !== expPc[i]) begin
                errors++;
                $display("FAIL ctrl_retire%0d got cyc=%0d pc=%h want cyc=%0d pc=%h",
                         i, retCyc[i], retPc[i], expCyc[i], expPc[i]);
            end
        end
        checks++;
        if (wrData.size() != 1 || wrData[0] !== 32'd1 || pc_out !== 32'h44) begin
            errors++;
            $display("FAIL ctrl_end got n=%0d data=%h pc=%h want 1 1 44",
                     wrData.size(), wrData[0], pc_out);
        end
    endtask

    task automatic test_faults();
        logic [31:0] inst  [4] = '{32'hFC00_0000, 32'h8C02_0041, 32'h8C02_0400, 32'h0800_0100};
        logic [1:0]  expC  [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
        logic [31:0] expPc [4] = '{32'h0, 32'h0, 32'h0, 32'h400};
        int          expRet[4] = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            clearMem();
            mem[0] = inst[k];
            startRun();
            waitHalt(50, "fault");
            repeat (5) @(negedge clk);
            checks++;
            if (halted !== 1'b1 || halt_cause !== expC[k] || pc_out !== expPc[k]) begin
                errors++;
                $display("FAIL fault%0d got halted=%b cause=%0d pc=%h want 1 %0d %h",
                         k, halted, halt_cause, pc_out, expC[k], expPc[k]);
            end
            checks++;
            if (reqCnt != 1 || retCyc.size() != expRet[k] || retire !== 1'b0) begin
                errors++;
                $display("FAIL fault%0d_bus got reqs=%0d retires=%0d want 1 %0d",
                         k, reqCnt, retCyc.size(), expRet[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        clearMem();
        mem[0] = 32'h2001_0009;
        startRun();
        waitHalt(50, "arst_pre");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || halt_cause !== 2'd0 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL arst_clear got halted=%b cause=%0d pc=%h want 0 0 0",
                     halted, halt_cause, pc_out);
        end
        readyHold = 1'b1;
        startRun();
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 10'h0) begin
            errors++;
            $display("FAIL arst_stall got req=%b addr=%h want 1 000", mem_req, mem_addr);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL arst_req_drop got %b want 0", mem_req);
        end
        readyHold = 1'b0;
        mem[0]    = 32'hAC01_0080;
        startRun();
        waitHalt(50, "arst_post");
        checks++;
        if (wrData.size() != 1 || wrData[0] !== 32'h0 || retPc[0] !== 32'h0) begin
            errors++;
            $display("FAIL arst_regs got n=%0d data=%h pc=%h want 1 0 0",
                     wrData.size(), wrData[0], retPc[0]);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_alu();
        test_wait_states();
        test_load_store();
        test_control_flow();
        test_faults();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
